// File: rtl/clk_edge_meter_pkg.sv
// Shared constants for the slow-clock edge meter: FSM encoding and default sizes.
package clk_edge_meter_pkg;

   typedef logic [1:0] meterState_t;

   localparam meterState_t ST_IDLE = 2'd0;
   localparam meterState_t ST_ARM  = 2'd1;
   localparam meterState_t ST_HALF = 2'd2;
   localparam meterState_t ST_LOCK = 2'd3;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 26;
   localparam int DEF_TIMEOUT     = 50000000;

endpackage

// File: rtl/clk_edge_meter_sync_edge_detect.sv
// Brings the asynchronous slow clock into Clk through a flop chain and
// flags its synchronized rising and falling edges.
module sync_edge_detect
   import clk_edge_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic Clk,
   input  logic Rst,
   input  logic SlowIn,
   output logic s,
   output logic Level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] syncReg;
   logic [SYNC_STAGES-1:0] syncNext;
   logic                   prevReg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : gStage
         if (gi == 0) begin : gFirst
            assign syncNext[gi] = SlowIn;
         end else begin : gRest
            assign syncNext[gi] = syncReg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Rst) begin
         syncReg <= '0;
         prevReg <= 1'b0;
      end else begin
         syncReg <= syncNext;
         prevReg <= syncReg[SYNC_STAGES-1];
      end
   end

   assign s     = syncReg[SYNC_STAGES-1];
   assign Level = prevReg;
   assign rise  = s & ~prevReg;
   assign fall  = ~s & prevReg;

endmodule

// File: rtl/clk_edge_meter.sv
// Measures high/low/period of a slow clock in Clk cycles, emits edge ticks
// and flags loss of the slow clock.
module clk_edge_meter
   import clk_edge_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter bit TIMEOUT_EN  = 1'b1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             SlowIn,
   output logic             Level,
   output logic             RiseTick,
   output logic             FallTick,
   output logic [CNT_W-1:0] HalfHigh,
   output logic [CNT_W-1:0] HalfLow,
   output logic [CNT_W:0]   Period,
   output logic             PeriodValid,
   output logic             Timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   logic             syncS;
   logic             rise;
   logic             fall;
   logic             edgeNow;
   logic             timeoutHit;
   logic             captureEn;
   logic [CNT_W-1:0] cntReg;
   logic [CNT_W-1:0] cntInc;
   meterState_t      stateReg;
   meterState_t      stateNext;
   logic             riseTickReg;
   logic             fallTickReg;
   logic [CNT_W-1:0] halfHighReg;
   logic [CNT_W-1:0] halfLowReg;
   logic [CNT_W:0]   periodReg;
   logic             periodValidReg;
   logic             timeoutReg;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) uSync (
      .Clk   (Clk),
      .Rst   (Rst),
      .SlowIn(SlowIn),
      .s     (syncS),
      .Level (Level),
      .rise  (rise),
      .fall  (fall)
   );

   assign edgeNow    = syncS ^ Level;
   // Saturating increment doubles as the captured length of the finishing phase.
   assign cntInc     = (cntReg == CNT_MAX) ? CNT_MAX : cntReg + 1'b1;
   assign timeoutHit = TIMEOUT_EN && (cntReg == TO_LAST) && !edgeNow;
   assign captureEn  = edgeNow && (stateReg != ST_IDLE);

   always_comb begin
      stateNext = stateReg;
      if (timeoutHit) begin
         stateNext = ST_IDLE;
      end else if (edgeNow) begin
         case (stateReg)
            ST_IDLE: stateNext = ST_ARM;
            ST_ARM:  stateNext = ST_HALF;
            default: stateNext = ST_LOCK;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cntReg         <= '0;
         stateReg       <= ST_IDLE;
         riseTickReg    <= 1'b0;
         fallTickReg    <= 1'b0;
         halfHighReg    <= '0;
         halfLowReg     <= '0;
         periodReg      <= '0;
         periodValidReg <= 1'b0;
         timeoutReg     <= 1'b0;
      end else begin
         cntReg      <= edgeNow ? '0 : cntInc;
         stateReg    <= stateNext;
         riseTickReg <= rise;
         fallTickReg <= fall;
         if (captureEn && rise) halfLowReg <= cntInc;
         if (captureEn && fall) halfHighReg <= cntInc;
         periodReg      <= {1'b0, halfHighReg} + {1'b0, halfLowReg};
         periodValidReg <= (stateReg == ST_LOCK) && !timeoutHit;
         if (timeoutHit) begin
            timeoutReg <= 1'b1;
         end else if (edgeNow) begin
            timeoutReg <= 1'b0;
         end
      end
   end

   assign RiseTick    = riseTickReg;
   assign FallTick    = fallTickReg;
   assign HalfHigh    = halfHighReg;
   assign HalfLow     = halfLowReg;
   assign Period      = periodReg;
   assign PeriodValid = periodValidReg;
   assign Timeout     = timeoutReg;

endmodule

// File: tb/tb_clk_edge_meter.sv
// Directed bench: a 26-bit meter with a short timeout, plus a 4-bit meter
// with timeout disabled to exercise capture saturation.
module tb_clk_edge_meter;

   localparam int CW1 = 26;
   localparam int CW2 = 4;

   logic           Clk = 1'b0;
   logic           Rst;
   logic           SlowIn;
   logic           SlowIn2;

   logic           Level, RiseTick, FallTick, PeriodValid, Timeout;
   logic [CW1-1:0] HalfHigh, HalfLow;
   logic [CW1:0]   Period;

   logic           Level2, RiseTick2, FallTick2, PeriodValid2, Timeout2;
   logic [CW2-1:0] HalfHigh2, HalfLow2;
   logic [CW2:0]   Period2;

   int nAsserts = 0;
   int nFail    = 0;

   always #5 Clk = ~Clk;

   clk_edge_meter #(
      .SYNC_STAGES(2), .CNT_W(CW1), .TIMEOUT(64), .TIMEOUT_EN(1'b1)
   ) dut (
      .Clk(Clk), .Rst(Rst), .SlowIn(SlowIn), .Level(Level),
      .RiseTick(RiseTick), .FallTick(FallTick), .HalfHigh(HalfHigh),
      .HalfLow(HalfLow), .Period(Period), .PeriodValid(PeriodValid),
      .Timeout(Timeout)
   );

   clk_edge_meter #(
      .SYNC_STAGES(2), .CNT_W(CW2), .TIMEOUT(15), .TIMEOUT_EN(1'b0)
   ) dutSat (
      .Clk(Clk), .Rst(Rst), .SlowIn(SlowIn2), .Level(Level2),
      .RiseTick(RiseTick2), .FallTick(FallTick2), .HalfHigh(HalfHigh2),
      .HalfLow(HalfLow2), .Period(Period2), .PeriodValid(PeriodValid2),
      .Timeout(Timeout2)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_level"},   32'(Level), 0);
      check({tag, "_rise"},    32'(RiseTick), 0);
      check({tag, "_fall"},    32'(FallTick), 0);
      check({tag, "_hhigh"},   32'(HalfHigh), 0);
      check({tag, "_hlow"},    32'(HalfLow), 0);
      check({tag, "_period"},  32'(Period), 0);
      check({tag, "_pvalid"},  32'(PeriodValid), 0);
      check({tag, "_timeout"}, 32'(Timeout), 0);
   endtask

   initial begin
      int expLow;
      Rst     = 1'b1;
      SlowIn  = 1'b0;
      SlowIn2 = 1'b0;
      tick(3);
      checkAllZero("reset");
      $display("step reset: outputs checked");
      Rst = 1'b0;
      tick(2);

      // 10/10 square wave: edge 1 -> ARM, edge 2 -> HALF, edge 3 -> LOCK
      SlowIn = 1'b1;
      tick(2);  check("rise_early", 32'(RiseTick), 0);
      tick(1);  check("rise_tick", 32'(RiseTick), 1);
                check("rise_nofall", 32'(FallTick), 0);
      tick(1);  check("rise_one_cycle", 32'(RiseTick), 0);
      tick(6);
      SlowIn = 1'b0;
      tick(3);  check("fall_tick", 32'(FallTick), 1);
                check("sq_hhigh", 32'(HalfHigh), 10);
                check("sq_pvalid_e2", 32'(PeriodValid), 0);
      tick(1);  check("fall_one_cycle", 32'(FallTick), 0);
      tick(6);
      SlowIn = 1'b1;
      tick(3);  check("sq_hlow", 32'(HalfLow), 10);
                check("sq_pvalid_e3", 32'(PeriodValid), 0);
      tick(1);  check("sq_pvalid", 32'(PeriodValid), 1);
                check("sq_period", 32'(Period), 20);
      $display("step square 10/10: HalfHigh=%0d HalfLow=%0d Period=%0d", HalfHigh, HalfLow, Period);
      tick(6);
      SlowIn = 1'b0;
      tick(10);

      // Asymmetric 7 high / 13 low
      for (int p = 0; p < 6; p++) begin
         SlowIn = 1'b1;
         tick(7);
         SlowIn = 1'b0;
         tick(13);
         expLow = (p == 0) ? 10 : 13;
         check("asym_hhigh", 32'(HalfHigh), 7);
         check("asym_hlow", 32'(HalfLow), 32'(expLow));
         check("asym_period", 32'(Period), 32'(7 + expLow));
         check("asym_pvalid", 32'(PeriodValid), 1);
         $display("step asym period %0d: HalfHigh=%0d HalfLow=%0d Period=%0d", p, HalfHigh, HalfLow, Period);
      end

      // Slow clock lost: last FallTick was 10 cycles ago, timeout 64 after it
      tick(53); check("to_early", 32'(Timeout), 0);
                check("to_early_pvalid", 32'(PeriodValid), 1);
      tick(1);  check("to_set", 32'(Timeout), 1);
                check("to_pvalid", 32'(PeriodValid), 0);
                check("to_hhigh_hold", 32'(HalfHigh), 7);
                check("to_hlow_hold", 32'(HalfLow), 13);
                check("to_period_hold", 32'(Period), 20);
      $display("step timeout: Timeout=%0d PeriodValid=%0d", Timeout, PeriodValid);

      // Restart: first edge clears Timeout and is not captured
      SlowIn = 1'b1;
      tick(2);  check("re_to_still", 32'(Timeout), 1);
      tick(1);  check("re_to_clear", 32'(Timeout), 0);
                check("re_rise", 32'(RiseTick), 1);
                check("re_idle_nocap", 32'(HalfLow), 13);
      tick(7);
      SlowIn = 1'b0;
      tick(3);  check("re_hhigh", 32'(HalfHigh), 10);
                check("re_pvalid_e2", 32'(PeriodValid), 0);
      tick(7);
      SlowIn = 1'b1;
      tick(3);  check("re_hlow", 32'(HalfLow), 10);
                check("re_pvalid_e3", 32'(PeriodValid), 0);
      tick(1);  check("re_pvalid", 32'(PeriodValid), 1);
                check("re_period", 32'(Period), 20);
      $display("step restart: PeriodValid=%0d Period=%0d", PeriodValid, Period);

      // Reset mid-LOCK with SlowIn high
      Rst = 1'b1;
      tick(1);  checkAllZero("midrst");
      Rst = 1'b0;
      tick(2);  check("midrst_rise_early", 32'(RiseTick), 0);
      tick(1);  check("midrst_rise", 32'(RiseTick), 1);
                check("midrst_pvalid_e1", 32'(PeriodValid), 0);
      tick(6);
      SlowIn = 1'b0;
      tick(3);  check("midrst_hhigh", 32'(HalfHigh), 9);
                check("midrst_pvalid_e2", 32'(PeriodValid), 0);
      tick(7);
      SlowIn = 1'b1;
      tick(3);  check("midrst_hlow", 32'(HalfLow), 10);
      tick(1);  check("midrst_pvalid", 32'(PeriodValid), 1);
                check("midrst_period", 32'(Period), 19);
      $display("step reset mid-lock: HalfHigh=%0d HalfLow=%0d Period=%0d", HalfHigh, HalfLow, Period);

      // Edge lands exactly on cnt == TIMEOUT-1: no timeout, capture = TIMEOUT
      tick(60);
      SlowIn = 1'b0;
      tick(2);  check("bnd_to_pre", 32'(Timeout), 0);
      tick(1);  check("bnd_to", 32'(Timeout), 0);
                check("bnd_fall", 32'(FallTick), 1);
                check("bnd_hhigh", 32'(HalfHigh), 64);
      tick(1);  check("bnd_period", 32'(Period), 74);
                check("bnd_pvalid", 32'(PeriodValid), 1);
      $display("step boundary: HalfHigh=%0d Timeout=%0d", HalfHigh, Timeout);

      // CNT_W=4 meter, 20-cycle halves saturate at 15
      for (int p = 0; p < 2; p++) begin
         SlowIn2 = 1'b1;
         tick(20);
         SlowIn2 = 1'b0;
         tick(20);
      end
      SlowIn2 = 1'b1;
      tick(4);
      check("sat_hhigh", 32'(HalfHigh2), 15);
      check("sat_hlow", 32'(HalfLow2), 15);
      check("sat_period", 32'(Period2), 30);
      check("sat_pvalid", 32'(PeriodValid2), 1);
      check("sat_timeout", 32'(Timeout2), 0);
      $display("step saturation: HalfHigh=%0d HalfLow=%0d Period=%0d", HalfHigh2, HalfLow2, Period2);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
